// File: rtl/riscv_crypto_sbox_aes_pipe.sv
// Multi-lane pipelined AES S-box / inverse S-box with elastic valid/ready and flush.
// The GF(2^8) inverse middle layer is shared; mode selects the affine top/bottom layers.

module riscv_crypto_sbox_aes_lane (
    input  logic       inv_top,
    input  logic [7:0] x_top,
    output logic [7:0] y_top,
    input  logic [7:0] x_mid,
    output logic [7:0] y_mid,
    input  logic       inv_bot,
    input  logic       mask_bot,
    input  logic [7:0] orig_bot,
    input  logic [7:0] x_bot,
    output logic [7:0] y_bot
);
    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    always_comb begin
        y_top = x_top;
        if (inv_top) y_top = rotl(x_top, 1) ^ rotl(x_top, 3) ^ rotl(x_top, 6) ^ 8'h05;
        y_mid = ginv(x_mid);
        y_bot = x_bot;
        if (!inv_bot)
            y_bot = x_bot ^ rotl(x_bot, 1) ^ rotl(x_bot, 2) ^ rotl(x_bot, 3) ^ rotl(x_bot, 4) ^ 8'h63;
        if (!mask_bot) y_bot = orig_bot;
    end
endmodule

module riscv_crypto_sbox_aes_pipe #(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [8*LANES-1:0]   in_data_i,
    input  logic                 in_inv_i,
    input  logic [LANES-1:0]     in_mask_i,
    input  logic [TAG_W-1:0]     in_tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [8*LANES-1:0]   out_data_o,
    output logic [TAG_W-1:0]     out_tag_o
);
    typedef struct packed {
        logic                  inv;
        logic [LANES-1:0]      mask;
        logic [TAG_W-1:0]      tag;
        logic [LANES-1:0][7:0] orig;
        logic [LANES-1:0][7:0] cur;
    } ent_t;

    ent_t in_e, a_c, a, b_c, b, c_c;
    ent_t d [STAGES];
    ent_t q [STAGES];
    logic [STAGES-1:0] v, ld, vin;
    logic [LANES-1:0][7:0] top_y, mid_y, bot_y;
    logic accept;

    assign in_e = '{inv: in_inv_i, mask: in_mask_i, tag: in_tag_i, orig: in_data_i, cur: in_data_i};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        riscv_crypto_sbox_aes_lane u_lane (
            .inv_top  (in_e.inv),
            .x_top    (in_e.cur[k]),
            .y_top    (top_y[k]),
            .x_mid    (a.cur[k]),
            .y_mid    (mid_y[k]),
            .inv_bot  (b.inv),
            .mask_bot (b.mask[k]),
            .orig_bot (b.orig[k]),
            .x_bot    (b.cur[k]),
            .y_bot    (bot_y[k])
        );
    end

    always_comb begin
        a_c = in_e;
        a_c.cur = top_y;
        b_c = a;
        b_c.cur = mid_y;
        c_c = b;
        c_c.cur = bot_y;
    end

    // Register boundaries: after top layer (STAGES>=2), after middle (STAGES==3), output always
    if (STAGES >= 2) begin : g_reg_a
        assign a    = q[0];
        assign d[0] = a_c;
    end else begin : g_pass_a
        assign a = a_c;
    end
    if (STAGES == 3) begin : g_reg_b
        assign b    = q[1];
        assign d[1] = b_c;
    end else begin : g_pass_b
        assign b = b_c;
    end
    assign d[STAGES-1] = c_c;

    // A stage may load when it or any later stage is empty, or the output drains
    for (genvar s = 0; s < STAGES; s++) begin : g_ld
        assign ld[s] = out_ready_i | ~(&v[STAGES-1:s]);
    end

    assign in_ready_o = ~flush_i & ld[0];
    assign accept     = in_valid_i & in_ready_o;

    if (STAGES == 1) begin : g_vin1
        assign vin = accept;
    end else begin : g_vinn
        assign vin = {v[STAGES-2:0], accept};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int s = 0; s < STAGES; s++) q[s] <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (flush_i) begin
                    v[s] <= 1'b0;
                end else if (ld[s]) begin
                    v[s] <= vin[s];
                    if (vin[s]) q[s] <= d[s];
                end
            end
        end
    end

    assign out_valid_o = v[STAGES-1];
    assign out_data_o  = q[STAGES-1].cur;
    assign out_tag_o   = q[STAGES-1].tag;
endmodule

// File: tb/tb_riscv_crypto_sbox_aes_pipe.sv
// Directed bench for riscv_crypto_sbox_aes_pipe: vector table, stream, backpressure,
// flush and async reset sequences, with a FIPS-197 table scoreboard.

module tb_riscv_crypto_sbox_aes_pipe;
    localparam int LANES = 4, STAGES = 2, TAG_W = 5, DW = 8 * LANES;

    logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
    logic in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [DW-1:0] in_data = '0, out_data;
    logic [LANES-1:0] in_mask = '0;
    logic [TAG_W-1:0] in_tag = '0, out_tag;

    always #5 clk = ~clk;

    riscv_crypto_sbox_aes_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_inv_i(in_inv), .in_mask_i(in_mask), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_tag_o(out_tag)
    );

    localparam logic [2047:0] SB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [7:0] isb [256];
    int checks = 0, errors = 0, pops = 0;

    typedef struct { logic [DW-1:0] data; logic [TAG_W-1:0] tag; } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [DW-1:0] data; logic inv; logic [LANES-1:0] mask;
        logic [TAG_W-1:0] tag; logic [DW-1:0] exp;
    } vec_t;
    vec_t vt[8];

    function automatic logic [7:0] sb(input logic [7:0] x);
        int i;
        i = int'(x);
        return SB[2047-8*i -: 8];
    endfunction

    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic inv, input logic [LANES-1:0] m);
        logic [DW-1:0] r;
        r = d;
        for (int k = 0; k < LANES; k++)
            if (m[k]) r[8*k +: 8] = inv ? isb[d[8*k +: 8]] : sb(d[8*k +: 8]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: handshakes seen mid-cycle complete at the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready && !flush) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 64'(out_tag), 64'hffff);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.data));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                    pops++;
                end
            end
            if (flush) sbq.delete();
            else if (in_valid && in_ready) sbq.push_back('{model(in_data, in_inv, in_mask), in_tag});
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic inv, input logic [LANES-1:0] m, input logic [TAG_W-1:0] t);
        in_data = d; in_inv = inv; in_mask = m; in_tag = t; in_valid = 1'b1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [DW-1:0] d, input logic inv, input logic [LANES-1:0] m, input logic [TAG_W-1:0] t);
        int n;
        n = 0;
        drive(d, inv, m, t);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk(name, 64'(n), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] hold, d;
        int p0;
        vt[0] = '{32'h53FF0100, 1'b0, 4'hF, 5'd1, 32'hED167C63};
        vt[1] = '{32'h00ED1663, 1'b1, 4'hF, 5'd2, 32'h5253FF00};
        vt[2] = '{32'h00000000, 1'b0, 4'h5, 5'd3, 32'h00630063};
        vt[3] = '{32'h12345678, 1'b0, 4'h0, 5'd4, 32'h12345678};
        vt[4] = '{32'h637C777B, 1'b1, 4'hF, 5'd5, 32'h00010203};
        vt[5] = '{32'h0001020F, 1'b0, 4'hF, 5'd6, 32'h637C7776};
        vt[6] = '{32'h52ED0009, 1'b1, 4'hA, 5'd7, 32'h48ED5209};
        vt[7] = '{32'hFFFEFDFC, 1'b0, 4'hF, 5'd8, 32'h16BB54B0};
        for (int i = 0; i < 256; i++) isb[sb(8'(i))] = 8'(i);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Single transactions: exact latency and hand-computed results
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 drive(vt[i].data, vt[i].inv, vt[i].mask, vt[i].tag);
            @(posedge clk);
            #1 in_valid = 1'b0;
            for (int c = 1; c < STAGES; c++) begin
                @(negedge clk);
                chk("lat_early", 64'(out_valid), 64'd0);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            chk("lat_valid", 64'(out_valid), 64'd1);
            chk("vec_data", 64'(out_data), 64'(vt[i].exp));
            chk("vec_tag", 64'(out_tag), 64'(vt[i].tag));
        end

        // Back-to-back stream with alternating modes
        @(posedge clk);
        #1 p0 = pops;
        for (int i = 0; i < 8; i++) send(vt[i].data, vt[i].inv, vt[i].mask, vt[i].tag);
        repeat (STAGES + 2) @(posedge clk);
        #1;
        chk("stream_count", 64'(pops - p0), 64'd8);
        chk("stream_empty", 64'(sbq.size()), 64'd0);

        // All 256 bytes, forward then inverse
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 64; i++) begin
                d = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
                send(d, m[0], 4'hF, 5'(i));
            end
        repeat (STAGES + 2) @(posedge clk);
        #1 chk("sweep_empty", 64'(sbq.size()), 64'd0);

        // Backpressure: 8 entries, output stalled for 5 cycles
        p0 = pops;
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 8; i++) send(32'hA0B0C0D0 + i * 32'h01010101, i[0], 4'hF, 5'(i + 8));
            begin
                repeat (3) @(negedge clk);
                hold = out_data;
                repeat (2) @(negedge clk);
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_valid_held", 64'(out_valid), 64'd1);
                chk("bp_data_stable", 64'(out_data), 64'(hold));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (STAGES + 4) @(posedge clk);
        #1;
        chk("bp_count", 64'(pops - p0), 64'd8);
        chk("bp_empty", 64'(sbq.size()), 64'd0);

        // Flush with pipeline full and a new input offered
        out_ready = 1'b0;
        send(32'h11111111, 1'b0, 4'hF, 5'd10);
        send(32'h22222222, 1'b1, 4'hF, 5'd11);
        drive(32'h33333333, 1'b0, 4'hF, 5'd20);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h44444444, 1'b0, 4'hF, 5'd21);
        wait_out("flush_wait");
        chk("flush_next_tag", 64'(out_tag), 64'd21);

        // Async reset mid-stream
        @(posedge clk);
        #1 drive(32'h01020304, 1'b0, 4'hF, 5'd1);
        @(posedge clk);
        #1 drive(32'h05060708, 1'b1, 4'hF, 5'd2);
        @(posedge clk);
        #2 chk("rst_pre_valid", 64'(out_valid), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_data", 64'(out_data), 64'd0);
        chk("rst_async_tag", 64'(out_tag), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        send(32'h53FF0100, 1'b0, 4'h3, 5'd7);
        wait_out("rst_wait");
        chk("rst_first_data", 64'(out_data), 64'h53FF7C63);
        chk("rst_first_tag", 64'(out_tag), 64'd7);
        repeat (3) @(posedge clk);
        #1 chk("final_empty", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
